// File: rtl/bcd_scan_display.sv
// Memory-mapped multiplexed seven-segment controller: CTRL/HEX/RAW registers on the CPU bus,
// autonomous digit scanning with hex decode, raw segments, decimal points and blanking.
module bcd_scan_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        Address,
  input  logic [31:0]       Write_data,
  output logic [31:0]       Read_data,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        seg
);

  localparam int              PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   PRE_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [1:0]      IDX_LAST  = 2'(DIGITS - 1);
  localparam logic [31:0]     DIG_MASK  = 32'hFFFF_FFFF >> (32 - DIGITS);
  localparam logic [31:0]     CTRL_MASK = (DIG_MASK << 12) | (DIG_MASK << 4) | 32'h3;
  localparam logic [31:0]     HEX_MASK  = 32'hFFFF_FFFF >> (32 - 4 * DIGITS);
  localparam logic [31:0]     RAW_MASK  = 32'hFFFF_FFFF >> (32 - 8 * DIGITS);

  typedef enum logic [1:0] {
    ADDR_CTRL = 2'd0,
    ADDR_HEX  = 2'd1,
    ADDR_RAW  = 2'd2,
    ADDR_SCAN = 2'd3
  } addr_e;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  logic [31:0]       ctrl_q, ctrl_d, hex_q, hex_d, raw_q, raw_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [1:0]        idx_q, idx_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;

  logic              en, raw_mode, dp_bit, blank_bit;
  logic [3:0]        dp_mask, blank_mask;
  logic [3:0][3:0]   hex_nib;
  logic [3:0][7:0]   raw_byte;

  // Mask bits beyond DIGITS are always stored as 0, so the 4-wide views are safe for any DIGITS.
  assign en         = ctrl_q[0];
  assign raw_mode   = ctrl_q[1];
  assign dp_mask    = ctrl_q[7:4];
  assign blank_mask = ctrl_q[15:12];
  assign hex_nib    = hex_q[15:0];
  assign raw_byte   = raw_q;
  assign dp_bit     = dp_mask[idx_q];
  assign blank_bit  = blank_mask[idx_q];

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    ctrl_d = ctrl_q;
    hex_d  = hex_q;
    raw_d  = raw_q;
    if (MemWrite) begin
      case (addr_e'(Address))
        ADDR_CTRL: ctrl_d = Write_data & CTRL_MASK;
        ADDR_HEX:  hex_d  = Write_data & HEX_MASK;
        ADDR_RAW:  raw_d  = Write_data & RAW_MASK;
        default:   ;
      endcase
    end

    pre_d = '0;
    idx_d = '0;
    if (en) begin
      if (pre_q == PRE_LAST) begin
        idx_d = (idx_q == IDX_LAST) ? 2'd0 : idx_q + 2'd1;
      end else begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
      end
    end

    sel_d = '0;
    seg_d = '0;
    if (en) begin
      sel_d = DIGITS'(1) << idx_q;
      if (blank_bit)     seg_d = 8'h00;
      else if (raw_mode) seg_d = raw_byte[idx_q];
      else               seg_d = {dp_bit, hex7(hex_nib[idx_q])};
    end
  end

  always_comb begin
    Read_data = '0;
    if (MemRead) begin
      case (addr_e'(Address))
        ADDR_CTRL: Read_data = ctrl_q;
        ADDR_HEX:  Read_data = hex_q;
        ADDR_RAW:  Read_data = raw_q;
        default:   Read_data = {30'b0, idx_q};
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
      hex_q  <= '0;
      raw_q  <= '0;
      pre_q  <= '0;
      idx_q  <= '0;
      sel_q  <= '0;
      seg_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      hex_q  <= hex_d;
      raw_q  <= raw_d;
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with DIGITS=4, SCAN_DIV=4: table-driven scan and bus
// vectors plus hand-written sequences for mode changes, disable/re-enable and async reset.
module tb_bcd_scan_display;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_HEX  = 2'd1;
  localparam logic [1:0] A_RAW  = 2'd2;
  localparam logic [1:0] A_SCAN = 2'd3;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] seg;
  } pin_t;

  typedef struct packed {
    logic [1:0]  addr;
    logic        rd;
    logic [31:0] exp;
  } bus_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              MemRead = 1'b0;
  logic              MemWrite = 1'b0;
  logic [1:0]        Address = 2'd0;
  logic [31:0]       Write_data = 32'd0;
  logic [31:0]       Read_data;
  logic [DIGITS-1:0] sel;
  logic [7:0]        seg;

  int total = 0;
  int bad   = 0;

  pin_t hex_tab  [17];
  pin_t mode_tab [4];
  bus_t bus_tab  [8];

  bcd_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .sel        (sel),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_pins(input string name, input logic [3:0] es, input logic [7:0] eg);
    check({name, " sel"}, 32'(sel), 32'(es));
    check({name, " seg"}, 32'(seg), 32'(eg));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Address    = a;
    Write_data = d;
    MemWrite   = 1'b1;
    @(posedge clk);
    #1;
    MemWrite   = 1'b0;
    Write_data = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Address = a;
    MemRead = 1'b1;
    #1;
    d = Read_data;
    MemRead = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;

    hex_tab = '{
      '{4'b0001, 8'h7F}, '{4'b0001, 8'h7F}, '{4'b0001, 8'h7F}, '{4'b0001, 8'h7F},
      '{4'b0010, 8'h71}, '{4'b0010, 8'h71}, '{4'b0010, 8'h71}, '{4'b0010, 8'h71},
      '{4'b0100, 8'h06}, '{4'b0100, 8'h06}, '{4'b0100, 8'h06}, '{4'b0100, 8'h06},
      '{4'b1000, 8'h77}, '{4'b1000, 8'h77}, '{4'b1000, 8'h77}, '{4'b1000, 8'h77},
      '{4'b0001, 8'h7F}
    };
    mode_tab = '{ '{4'b0001, 8'h00}, '{4'b0010, 8'h00}, '{4'b0100, 8'hFF}, '{4'b1000, 8'h80} };
    bus_tab = '{
      '{A_CTRL, 1'b1, 32'h0000_2010}, '{A_HEX,  1'b1, 32'h0000_A5F0},
      '{A_RAW,  1'b1, 32'h80FF_5500}, '{A_SCAN, 1'b1, 32'h0000_0000},
      '{A_CTRL, 1'b0, 32'h0},         '{A_HEX,  1'b0, 32'h0},
      '{A_RAW,  1'b0, 32'h0},         '{A_SCAN, 1'b0, 32'h0}
    };

    // Power-on reset state
    #12 reset = 1'b1;
    step();
    check_pins("reset", 4'b0000, 8'h00);
    rd(A_CTRL, r); check("reset ctrl", r, 32'h0);

    // Hex scan: frame of four digits, four cycles each, then wrap
    wr(A_HEX, 32'h0000_A1F8);
    wr(A_CTRL, 32'h0000_0001);
    for (int k = 0; k < 17; k++) begin
      step();
      check_pins($sformatf("hex c%0d", k + 1), hex_tab[k].sel, hex_tab[k].seg);
    end

    // Raw mode with digit1 blanked; DP mask ignored in raw mode
    wr(A_CTRL, 32'h0);
    wr(A_RAW, 32'h80FF_5500);
    wr(A_CTRL, 32'h0000_2013);
    for (int k = 1; k <= 16; k++) begin
      step();
      check_pins($sformatf("raw c%0d", k), mode_tab[(k - 1) / 4].sel, mode_tab[(k - 1) / 4].seg);
    end

    // Hex mode with DP on digit0, digit1 still blanked
    wr(A_CTRL, 32'h0000_2010);
    wr(A_HEX, 32'h0000_A1F0);
    wr(A_CTRL, 32'h0000_2011);
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 1) check_pins("dp c1", 4'b0001, 8'hBF);
      if (k == 5) check_pins("blank c5", 4'b0010, 8'h00);
      if (k == 9) check_pins("hex2 c9", 4'b0100, 8'h06);
    end

    // Write during scan: new nibble appears one cycle after the write edge, scan undisturbed
    wr(A_HEX, 32'h0000_A5F0);
    check_pins("wr-scan c10", 4'b0100, 8'h06);
    step();
    check_pins("wr-scan c11", 4'b0100, 8'h6D);

    // Disable on digit 2, then re-enable from digit 0 with full dwell
    wr(A_CTRL, 32'h0000_2010);
    check_pins("dis edge", 4'b0100, 8'h6D);
    step();
    check_pins("dis next", 4'b0000, 8'h00);
    rd(A_SCAN, r); check("dis scan", r, 32'h0);
    wr(A_CTRL, 32'h0000_2011);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k <= 4) check_pins($sformatf("reen c%0d", k), 4'b0001, 8'hBF);
      else        check_pins("reen c5", 4'b0010, 8'h00);
    end

    // Bus reads with and without MemRead
    wr(A_CTRL, 32'h0000_2010);
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      Address = bus_tab[i].addr;
      MemRead = bus_tab[i].rd;
      #1;
      check($sformatf("bus a%0d r%0d", bus_tab[i].addr, bus_tab[i].rd), Read_data, bus_tab[i].exp);
      MemRead = 1'b0;
    end

    // SCAN is read-only; unimplemented bits read 0
    wr(A_SCAN, 32'hFFFF_FFFF);
    rd(A_CTRL, r); check("scanwr ctrl", r, 32'h0000_2010);
    rd(A_HEX,  r); check("scanwr hex",  r, 32'h0000_A5F0);
    rd(A_RAW,  r); check("scanwr raw",  r, 32'h80FF_5500);
    rd(A_SCAN, r); check("scanwr scan", r, 32'h0);
    step();
    wr(A_HEX, 32'hFFFF_FFFF);
    rd(A_HEX, r); check("hex mask", r, 32'h0000_FFFF);
    step();
    wr(A_RAW, 32'h1234_5678);
    rd(A_RAW, r); check("raw full", r, 32'h1234_5678);
    step();
    wr(A_CTRL, 32'hFFFF_FFFF);
    rd(A_CTRL, r); check("ctrl mask", r, 32'h0000_F0F3);
    step();
    check_pins("all blank", 4'b0001, 8'h00);

    // Asynchronous reset mid-scan, no clock edge needed
    for (int k = 0; k < 6; k++) step();
    #2 reset = 1'b0;
    #1;
    check_pins("async rst", 4'b0000, 8'h00);
    rd(A_CTRL, r); check("rst ctrl", r, 32'h0);
    rd(A_HEX,  r); check("rst hex",  r, 32'h0);
    rd(A_RAW,  r); check("rst raw",  r, 32'h0);
    rd(A_SCAN, r); check("rst scan", r, 32'h0);
    step();
    step();
    #3 reset = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check_pins("post rst", 4'b0000, 8'h00);
    rd(A_CTRL, r); check("post rst ctrl", r, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Memory-mapped, parametrised, multiplexed seven-segment display controller; successor to the single-register BCD status peripheral.
- Holds control, hex-digit and raw-segment registers on the CPU data bus.
- Autonomously time-multiplexes DIGITS digits onto one shared seg bus with a one-hot sel strobe.
- Supports hex decode, raw-segment mode, per-digit decimal points and per-digit blanking.

Parameters:
DIGITS, 4, number of multiplexed digits; legal range 1..4.
SCAN_DIV, 50000, clock cycles each digit stays selected; legal range >= 2.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
MemRead  input  1  read strobe; qualifies Read_data.
MemWrite  input  1  write strobe; one register written per cycle.
Address  input  2  register select: 0 CTRL, 1 HEX, 2 RAW, 3 SCAN.
Write_data  input  32  write data.
Read_data  output  32  read data; combinational.
sel  output  DIGITS  one-hot digit enable, active-high, registered.
seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-high, registered.

Behaviour:
- Reset (reset=0, asynchronous): CTRL, HEX, RAW, prescaler, digit index, sel and seg all 0. Registers stay held while reset=0.
- CTRL register: bit0 EN; bit1 RAW mode; bits[DIGITS+3:4] DP mask; bits[DIGITS+11:12] BLANK mask. Other bits ignored on write and read as 0.
- HEX register: bits[4*DIGITS-1:0]. Digit i uses nibble [4i+3:4i].
- RAW register: bits[8*DIGITS-1:0]. Digit i uses byte [8i+7:8i].
- SCAN register: read-only. bits[1:0] are the current digit index; all other bits are 0. Writes to SCAN are ignored.
- Register writes: on the posedge where MemWrite=1, the register at Address is updated. Unimplemented bits always read 0.
- Reads: Read_data = MemRead ? selected register : 32'b0, with zero latency.
- Prescaler and index when EN=1:
  - The prescaler counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the prescaler wraps to 0 and the index increments.
  - The index wraps from DIGITS-1 to 0.
- Prescaler and index when EN=0: both are forced to 0 on every clock. Re-enabling therefore always starts at digit 0 with a full dwell.
- Dwell: each digit is selected for exactly SCAN_DIV cycles. One full frame is DIGITS*SCAN_DIV cycles.
- Output pipeline: sel/seg are registered, computed at each posedge from the index and registers as they were before that edge. Latency is 1 cycle from any index or register change to the pins.
- EN=0: sel=0 and seg=0.
- EN=1: sel = 1<<index.
- seg when BLANK[index]=1: 8'h00. sel remains asserted.
- seg when BLANK[index]=0 and RAW=1: the RAW byte for the current digit, verbatim. The DP mask is ignored.
- seg when BLANK[index]=0 and RAW=0:
  - seg[6:0] is the hex decode of the current nibble.
  - Decode table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - seg[7] = DP[index].
- Write during scan: takes effect on the pins one cycle after the write edge. The scan is not disturbed unless EN is cleared.
- Reset mid-scan: immediate return to the reset state. After release, scanning requires a fresh EN write.

Test Plan:
1. Reset: drive reset=0 mid-scan with EN=1 -> sel=0, seg=0 and all register reads 0, immediately and without waiting for a clk edge.
2. Hex scan (DIGITS=4, SCAN_DIV=4): write HEX=32'h0000A1F8, then CTRL=1. Required pins, one cycle after the CTRL write edge:
   - cycles 1-4: sel=0001, seg=7F
   - cycles 5-8: sel=0010, seg=71
   - cycles 9-12: sel=0100, seg=06
   - cycles 13-16: sel=1000, seg=77
   - then wraps to sel=0001.
3. Modes: set CTRL=32'h00002013 (EN, RAW, BLANK digit1) with RAW=32'h80FF5500 -> digit0 seg=00, digit1 seg=00 (blanked, sel=0010), digit2 seg=FF, digit3 seg=80. Then clear RAW with DP mask=4'b0001 and HEX nibble0=0 -> digit0 seg=BF.
4. Disable/re-enable: clear EN while on digit 2 -> next cycle sel=0, seg=0, and a SCAN read returns 0. Set EN again -> digit 0 is selected for a full SCAN_DIV cycles.
5. Bus: read each address with MemRead=1 and MemRead=0 -> correct value and 0 respectively. Write 32'hFFFFFFFF to SCAN -> no change. Write 32'hFFFFFFFF to CTRL -> reads back 32'h0000F0F3 for DIGITS=4.
